// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// HIT gates the MEM/WB register. A load miss refills the whole line from main
// memory one beat per MM_READY. Every store is written through to main memory
// and only touches the cache when the line is already resident.
module dcache_ctrl #(
   parameter int LINES          = 16,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ADDRESS,
   input  logic [31:0] WRITE_DATA,
   input  logic        MEM_READ,
   input  logic        MEM_WRITE,
   output logic [31:0] READ_DATA,
   output logic        HIT,
   output logic [31:0] MM_ADDRESS,
   output logic        MM_READ,
   output logic        MM_WRITE,
   output logic [31:0] MM_WRITE_DATA,
   input  logic [31:0] MM_READ_DATA,
   input  logic        MM_READY
);

   localparam int OB = $clog2(WORDS_PER_LINE);   // word-offset bits
   localparam int IB = $clog2(LINES);            // index bits
   localparam int AW = IB + OB;                  // data array address bits
   localparam int TB = 30 - AW;                  // tag bits
   localparam int NW = LINES * WORDS_PER_LINE;
   localparam logic [OB-1:0] LAST_BEAT = OB'(WORDS_PER_LINE - 1);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_FILL      = 2'd1;
   localparam logic [1:0] ST_WRITE_MEM = 2'd2;
   localparam logic [1:0] ST_DONE      = 2'd3;

   // State and request latches
   logic [1:0]    state_reg, state_next;
   logic [29:0]   word_addr_reg, word_addr_next;   // latched word address
   logic [31:0]   wdata_reg, wdata_next;
   logic [OB-1:0] beat_reg, beat_next;
   logic          load_reg, load_next;             // latched request is a load

   // Line storage
   logic          valid_reg [LINES];
   logic [TB-1:0] tag_mem   [LINES];
   logic [31:0]   data_mem  [NW];

   // Array write controls decoded in the FSM
   logic          data_we;
   logic [AW-1:0] data_waddr;
   logic [31:0]   data_wdata;
   logic          fill_last;

   // Byte-lane bits carry no meaning for word accesses
   logic          addr_lsb_unused;
   assign addr_lsb_unused = ^ADDRESS[1:0];

   // Field split of the live request and of the latched request
   logic [OB-1:0] req_offset, lat_offset;
   logic [IB-1:0] req_index, lat_index;
   logic [TB-1:0] req_tag, lat_tag;
   logic          req_hit;
   logic [31:0]   req_word, done_word;

   assign req_offset = ADDRESS[OB+1:2];
   assign req_index  = ADDRESS[AW+1:OB+2];
   assign req_tag    = ADDRESS[31:AW+2];
   assign lat_offset = word_addr_reg[OB-1:0];
   assign lat_index  = word_addr_reg[AW-1:OB];
   assign lat_tag    = word_addr_reg[29:AW];

   // Asynchronous array reads: a load hit must answer in its own cycle
   assign req_hit   = valid_reg[req_index] && (tag_mem[req_index] == req_tag);
   assign req_word  = data_mem[{req_index, req_offset}];
   assign done_word = data_mem[{lat_index, lat_offset}];

   // Next-state, latch and output decode
   always_comb begin
      state_next     = state_reg;
      word_addr_next = word_addr_reg;
      wdata_next     = wdata_reg;
      beat_next      = beat_reg;
      load_next      = load_reg;
      HIT            = 1'b0;
      READ_DATA      = 32'd0;
      MM_ADDRESS     = 32'd0;
      MM_READ        = 1'b0;
      MM_WRITE       = 1'b0;
      MM_WRITE_DATA  = 32'd0;
      data_we        = 1'b0;
      data_waddr     = '0;
      data_wdata     = 32'd0;
      fill_last      = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (MEM_WRITE) begin
               // Store wins over a simultaneous load; write through always
               word_addr_next = ADDRESS[31:2];
               wdata_next     = WRITE_DATA;
               load_next      = 1'b0;
               beat_next      = '0;
               if (req_hit) begin
                  data_we    = 1'b1;
                  data_waddr = {req_index, req_offset};
                  data_wdata = WRITE_DATA;
               end
               state_next = ST_WRITE_MEM;
            end else if (MEM_READ) begin
               if (req_hit) begin
                  HIT       = 1'b1;
                  READ_DATA = req_word;
               end else begin
                  word_addr_next = ADDRESS[31:2];
                  load_next      = 1'b1;
                  beat_next      = '0;
                  state_next     = ST_FILL;
               end
            end else begin
               HIT = 1'b1;
            end
         end
         ST_FILL: begin
            MM_READ    = 1'b1;
            MM_ADDRESS = {lat_tag, lat_index, beat_reg, 2'b00};
            if (MM_READY) begin
               data_we    = 1'b1;
               data_waddr = {lat_index, beat_reg};
               data_wdata = MM_READ_DATA;
               beat_next  = beat_reg + OB'(1);
               if (beat_reg == LAST_BEAT) begin
                  fill_last  = 1'b1;
                  state_next = ST_DONE;
               end
            end
         end
         ST_WRITE_MEM: begin
            MM_WRITE      = 1'b1;
            MM_ADDRESS    = {word_addr_reg, 2'b00};
            MM_WRITE_DATA = wdata_reg;
            if (MM_READY) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            // The request still presented this cycle is the one being retired
            HIT = 1'b1;
            if (load_reg) begin
               READ_DATA = done_word;
            end
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // State, request latches and beat counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         word_addr_reg <= '0;
         wdata_reg     <= '0;
         beat_reg      <= '0;
         load_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         word_addr_reg <= word_addr_next;
         wdata_reg     <= wdata_next;
         beat_reg      <= beat_next;
         load_reg      <= load_next;
      end
   end

   // Per-line valid bit and tag; a line becomes valid only on its last fill beat
   genvar gi;
   generate
      for (gi = 0; gi < LINES; gi++) begin : g_line
         // Valid is cleared by reset so a partially filled line never hits
         always_ff @(posedge clk) begin
            if (rst) begin
               valid_reg[gi] <= 1'b0;
            end else if (fill_last && (lat_index == IB'(gi))) begin
               valid_reg[gi] <= 1'b1;
            end
         end

         // Tag is captured together with the valid bit
         always_ff @(posedge clk) begin
            if (!rst && fill_last && (lat_index == IB'(gi))) begin
               tag_mem[gi] <= lat_tag;
            end
         end
      end
   endgenerate

   // Data array write port: fill beats and store hits
   always_ff @(posedge clk) begin
      if (!rst && data_we) begin
         data_mem[data_waddr] <= data_wdata;
      end
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: a driver issues requests and pushes the
// expected responses and main-memory beats into queues; a monitor and a
// main-memory model pop and compare as the DUT produces them.
module tb_dcache_ctrl;

   localparam int LINES = 16;
   localparam int WPL   = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] ADDRESS = 32'd0;
   logic [31:0] WRITE_DATA = 32'd0;
   logic        MEM_READ = 1'b0;
   logic        MEM_WRITE = 1'b0;
   logic [31:0] READ_DATA;
   logic        HIT;
   logic [31:0] MM_ADDRESS;
   logic        MM_READ;
   logic        MM_WRITE;
   logic [31:0] MM_WRITE_DATA;
   logic [31:0] MM_READ_DATA = 32'd0;
   logic        MM_READY = 1'b0;

   dcache_ctrl #(.LINES(LINES), .WORDS_PER_LINE(WPL)) dut (
      .clk(clk), .rst(rst),
      .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA),
      .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
      .READ_DATA(READ_DATA), .HIT(HIT),
      .MM_ADDRESS(MM_ADDRESS), .MM_READ(MM_READ), .MM_WRITE(MM_WRITE),
      .MM_WRITE_DATA(MM_WRITE_DATA), .MM_READ_DATA(MM_READ_DATA), .MM_READY(MM_READY)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          is_store;
      logic [31:0] addr;
      logic [31:0] data;       // expected READ_DATA on completion
      int          issue_cyc;
      int          wait_snap;
      int          base_lat;   // latency with MM_READY always high
   } req_t;

   typedef struct {
      bit          is_write;
      logic [31:0] addr;
      logic [31:0] data;
   } mm_t;

   req_t req_q[$];
   mm_t  mm_q[$];
   req_t mon_r;
   mm_t  mm_e;

   // Reference: main memory contents plus which tag each line holds
   logic [31:0] ref_mem [int];
   logic [31:0] mm_mem  [int];
   bit          ref_valid [LINES];
   int          ref_tag   [LINES];

   int compared = 0, mismatched = 0;
   int issued_cnt = 0, completed_cnt = 0, last_lat = 0, txn_no = 0;
   int wait_total = 0, beats_served = 0, fixed_wait = 0;
   int wait_left = 0;
   bit in_wait = 0;
   logic [31:0] prev_addr, prev_wdata;
   logic [1:0]  prev_kind;

   function automatic logic [31:0] init_word(int w);
      logic [31:0] wv;
      wv = 32'(w);
      return (wv * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [31:0] ref_rd(int w);
      return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
   endfunction

   function automatic logic [31:0] mm_rd(int w);
      return mm_mem.exists(w) ? mm_mem[w] : init_word(w);
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic summary();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
   endtask

   task automatic abort(string what);
      compared++;
      mismatched++;
      $display("FAIL %s: got no completion expected completion (cycle %0d)", what, cyc);
      summary();
      $finish;
   endtask

   // Monitor: protocol rules every cycle, scoreboard pop on each completion
   always @(negedge clk) begin
      if (!rst) begin
         chk("mm_exclusive", 32'(MM_READ & MM_WRITE), 32'd0);
         if (!MM_READ && !MM_WRITE) begin
            chk("mm_addr_idle", MM_ADDRESS, 32'd0);
            chk("mm_wdata_idle", MM_WRITE_DATA, 32'd0);
         end
         if (!HIT) chk("rdata_no_hit", READ_DATA, 32'd0);
         if (!MEM_READ && !MEM_WRITE) begin
            chk("hit_no_req", 32'(HIT), 32'd1);
            chk("rdata_no_req", READ_DATA, 32'd0);
            chk("mm_read_no_req", 32'(MM_READ), 32'd0);
            chk("mm_write_no_req", 32'(MM_WRITE), 32'd0);
         end else if (HIT) begin
            if (req_q.size() == 0) begin
               chk("unexpected_completion", 32'd1, 32'd0);
            end else begin
               mon_r = req_q.pop_front();
               last_lat = cyc - mon_r.issue_cyc;
               chk("read_data", READ_DATA, mon_r.data);
               chk("latency", 32'(last_lat),
                   32'(mon_r.base_lat + (wait_total - mon_r.wait_snap)));
               txn_no++;
               $display("txn %0d: %s addr=%h rdata=%h lat=%0d", txn_no,
                        mon_r.is_store ? "store" : "load ", mon_r.addr, READ_DATA, last_lat);
               completed_cnt++;
            end
         end
      end
   end

   // Main-memory model: inserts wait cycles, serves beats, checks each beat
   initial begin
      forever begin
         @(negedge clk);
         MM_READY = 1'b0;
         MM_READ_DATA = 32'd0;
         if (rst || !(MM_READ || MM_WRITE)) begin
            in_wait = 0;
         end else begin
            if (in_wait) begin
               chk("mm_addr_stable", MM_ADDRESS, prev_addr);
               chk("mm_wdata_stable", MM_WRITE_DATA, prev_wdata);
               chk("mm_kind_stable", 32'({MM_READ, MM_WRITE}), 32'(prev_kind));
            end else begin
               in_wait = 1;
               wait_left = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 2));
            end
            prev_addr  = MM_ADDRESS;
            prev_wdata = MM_WRITE_DATA;
            prev_kind  = {MM_READ, MM_WRITE};
            if (wait_left > 0) begin
               wait_left--;
               wait_total++;
            end else begin
               MM_READY = 1'b1;
               in_wait = 0;
               beats_served++;
               if (mm_q.size() == 0) begin
                  chk("mm_unexpected_beat", MM_ADDRESS, 32'hFFFF_FFFF);
               end else begin
                  mm_e = mm_q.pop_front();
                  chk("mm_is_write", 32'(MM_WRITE), 32'(mm_e.is_write));
                  chk("mm_addr", MM_ADDRESS, mm_e.addr);
                  if (mm_e.is_write) chk("mm_wdata", MM_WRITE_DATA, mm_e.data);
               end
               if (MM_WRITE) mm_mem[int'(MM_ADDRESS[31:2])] = MM_WRITE_DATA;
               else MM_READ_DATA = mm_rd(int'(MM_ADDRESS[31:2]));
            end
         end
      end
   end

   // Present a request and push its expected outcome (called at posedge+1)
   task automatic issue_req(bit is_store, logic [31:0] addr, logic [31:0] data);
      req_t r;
      int w, idx, tag, line_w;
      w      = int'(addr[31:2]);
      idx    = (w / WPL) % LINES;
      tag    = w / (WPL * LINES);
      line_w = w - (w % WPL);
      r.is_store  = is_store;
      r.addr      = addr;
      r.issue_cyc = cyc;
      r.wait_snap = wait_total;
      if (is_store) begin
         r.base_lat = 2;
         r.data     = 32'd0;
         mm_q.push_back('{is_write: 1'b1, addr: {addr[31:2], 2'b00}, data: data});
         ref_mem[w] = data;
      end else begin
         r.data = ref_rd(w);
         if (ref_valid[idx] && ref_tag[idx] == tag) begin
            r.base_lat = 0;
         end else begin
            r.base_lat = WPL + 1;
            for (int b = 0; b < WPL; b++)
               mm_q.push_back('{is_write: 1'b0, addr: 32'((line_w + b) * 4), data: 32'd0});
            ref_valid[idx] = 1;
            ref_tag[idx]   = tag;
         end
      end
      req_q.push_back(r);
      ADDRESS    = addr;
      WRITE_DATA = is_store ? data : $urandom;
      MEM_WRITE  = is_store;
      MEM_READ   = is_store ? 1'($urandom_range(0, 1)) : 1'b1;
      issued_cnt++;
   endtask

   task automatic do_req(bit is_store, logic [31:0] addr, logic [31:0] data);
      int n;
      issue_req(is_store, addr, data);
      n = 0;
      while (completed_cnt != issued_cnt) begin
         @(posedge clk);
         #1;
         n++;
         if (n > 200) abort("request_timeout");
      end
      MEM_READ  = 1'b0;
      MEM_WRITE = 1'b0;
   endtask

   initial begin
      #1_000_000;
      abort("watchdog");
   end

   initial begin
      int base, n;
      for (int b = 0; b < WPL; b++) begin
         ref_mem[64 + b] = 32'hA0 + 32'(b);
         mm_mem[64 + b]  = 32'hA0 + 32'(b);
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;

      // Miss then hit on the same line
      fixed_wait = 0;
      do_req(0, 32'h0000_0104, 32'd0);
      chk("first_miss_lat", 32'(last_lat), 32'd5);
      do_req(0, 32'h0000_0108, 32'd0);
      chk("hit_lat", 32'(last_lat), 32'd0);
      // Conflict on index 0
      do_req(0, 32'h0000_0204, 32'd0);
      do_req(0, 32'h0000_0104, 32'd0);
      chk("conflict_reload_lat", 32'(last_lat), 32'd5);
      // Store hit, then read it back
      do_req(1, 32'h0000_0108, 32'hDEAD_BEEF);
      do_req(0, 32'h0000_0108, 32'd0);
      chk("store_hit_readback_lat", 32'(last_lat), 32'd0);
      // Store miss does not allocate
      do_req(1, 32'h0000_0300, 32'h1234_5678);
      do_req(0, 32'h0000_0300, 32'd0);
      chk("store_miss_no_alloc_lat", 32'(last_lat), 32'd5);
      // Slow memory, three wait cycles before every beat
      fixed_wait = 3;
      do_req(0, 32'h0000_0500, 32'd0);
      chk("slow_done_cycle", 32'(last_lat), 32'd17);
      fixed_wait = 0;

      // Reset after two fill beats
      issue_req(0, 32'h0000_0104, 32'd0);
      base = beats_served;
      n = 0;
      while (beats_served - base < 2) begin
         @(posedge clk);
         #1;
         n++;
         if (n > 50) abort("fill_beats_timeout");
      end
      rst = 1'b1;
      MEM_READ = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      req_q.delete();
      mm_q.delete();
      issued_cnt = completed_cnt;
      for (int i = 0; i < LINES; i++) ref_valid[i] = 0;
      @(negedge clk);
      chk("rst_mm_read", 32'(MM_READ), 32'd0);
      chk("rst_hit", 32'(HIT), 32'd1);
      @(posedge clk);
      #1;
      base = beats_served;
      do_req(0, 32'h0000_0104, 32'd0);
      chk("rst_refill_lat", 32'(last_lat), 32'd5);
      chk("rst_refill_beats", 32'(beats_served - base), 32'd4);

      // Randomized traffic over four tags per index with random memory waits
      fixed_wait = -1;
      repeat (300) begin
         do_req($urandom_range(0, 9) < 4, 32'($urandom_range(0, 1023)), $urandom);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end

      repeat (2) @(posedge clk);
      #1;
      chk("req_q_empty", 32'(req_q.size()), 32'd0);
      chk("mm_q_empty", 32'(mm_q.size()), 32'd0);
      summary();
      $finish;
   end

endmodule
